// File: rtl/hd_bundler.sv
// ---------------------------------------------------------------------------
// hd_bundler -- hypervector bundling unit.
//
// Keeps one saturating signed counter per hypervector bit. ACCUMULATE votes
// each bit of an operand into its counter. THRESHOLD turns the counters back
// into a binary vector, one slice per cycle, using a latched tie vector
// wherever a counter sits at zero. LOAD copies an operand straight into the
// output register, and CLEAR zeroes the counters and the sample count.
//
// Ports
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   valid_i       operation request
//   ready_o       high while idle; an operation is accepted on valid_i && ready_o
//   op_i          0 ACCUMULATE, 1 THRESHOLD, 2 LOAD, 3 CLEAR
//   src_sel_i     operand: 0 out_o, 1 mem_data_i, 2 zero, 3 out_o rotated left
//   mem_data_i    memory operand vector
//   tie_sel_i     tie source for THRESHOLD: 0 tie_value_i, 1 rotated out_o
//   tie_value_i   external tie vector
//   out_o         output hypervector register
//   sample_cnt_o  ACCUMULATEs since the last CLEAR, saturating at 65535
//   done_o        one-cycle pulse after each accepted operation completes
// ---------------------------------------------------------------------------
module hd_bundler #(
    parameter int DIMENSION   = 512,
    parameter int SLICE_WIDTH = 64,
    parameter int CNT_WIDTH   = 8,
    parameter int ROT_STEP    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [1:0]           op_i,
    input  logic [1:0]           src_sel_i,
    input  logic [DIMENSION-1:0] mem_data_i,
    input  logic                 tie_sel_i,
    input  logic [DIMENSION-1:0] tie_value_i,
    output logic [DIMENSION-1:0] out_o,
    output logic [15:0]          sample_cnt_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {
        OP_ACCUMULATE = 2'd0,
        OP_THRESHOLD  = 2'd1,
        OP_LOAD       = 2'd2,
        OP_CLEAR      = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        SRC_OUTPUT_REG     = 2'd0,
        SRC_MEMORY         = 2'd1,
        SRC_ZERO           = 2'd2,
        SRC_OUTPUT_REG_ROT = 2'd3
    } src_e;

    typedef enum logic {
        IDLE   = 1'b0,
        THRESH = 1'b1
    } state_e;

    localparam int NUM_SLICES = DIMENSION / SLICE_WIDTH;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int ROT        = ROT_STEP % DIMENSION;

    localparam logic signed [CNT_WIDTH-1:0] CNT_MAX  = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic signed [CNT_WIDTH-1:0] CNT_MIN  = {1'b1, {(CNT_WIDTH-1){1'b0}}};
    localparam logic signed [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic signed [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [IDX_W-1:0]            LAST_SLICE = IDX_W'(NUM_SLICES - 1);

    state_e                      state;
    state_e                      state_next;
    logic [IDX_W-1:0]            slice_idx;
    logic [DIMENSION-1:0]        tie_reg;
    logic [DIMENSION-1:0]        rotated;
    logic [DIMENSION-1:0]        operand;
    logic signed [CNT_WIDTH-1:0] counter [DIMENSION];
    logic                        accept;
    logic                        last_slice;
    op_e                         op;

    assign op         = op_e'(op_i);
    assign ready_o    = (state == IDLE);
    assign accept     = valid_i && ready_o;
    assign last_slice = (state == THRESH) && (slice_idx == LAST_SLICE);

    // Left rotation: bit i takes bit (i - ROT) mod DIMENSION. Operands are only
    // taken in IDLE, so out_o is never seen half-thresholded here.
    always_comb begin
        rotated = '0;
        for (int i = 0; i < DIMENSION; i++) begin
            rotated[i] = out_o[(i + DIMENSION - ROT) % DIMENSION];
        end
    end

    always_comb begin
        operand = '0;
        case (src_e'(src_sel_i))
            SRC_OUTPUT_REG:     operand = out_o;
            SRC_MEMORY:         operand = mem_data_i;
            SRC_ZERO:           operand = '0;
            SRC_OUTPUT_REG_ROT: operand = rotated;
            default:            operand = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && op == OP_THRESHOLD) state_next = THRESH;
            THRESH:  if (slice_idx == LAST_SLICE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all register updates use non-blocking assignments so every read
    // below sees the pre-edge value, e.g. counters during a slice update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_o        <= '0;
            tie_reg      <= '0;
            slice_idx    <= '0;
            sample_cnt_o <= '0;
            done_o       <= 1'b0;
            // NOTE: the counter array is live state, not a RAM, so every entry
            // is reset explicitly.
            for (int i = 0; i < DIMENSION; i++) begin
                counter[i] <= CNT_ZERO;
            end
        end else begin
            // Single-cycle ops finish on the accept edge; THRESHOLD finishes
            // on the edge that writes its last slice.
            done_o <= (accept && op != OP_THRESHOLD) || last_slice;

            if (accept) begin
                case (op)
                    OP_ACCUMULATE: begin
                        for (int i = 0; i < DIMENSION; i++) begin
                            if (operand[i]) begin
                                if (counter[i] != CNT_MAX) counter[i] <= counter[i] + CNT_ONE;
                            end else begin
                                if (counter[i] != CNT_MIN) counter[i] <= counter[i] - CNT_ONE;
                            end
                        end
                        if (sample_cnt_o != 16'hFFFF) sample_cnt_o <= sample_cnt_o + 16'd1;
                    end
                    OP_THRESHOLD: begin
                        tie_reg   <= tie_sel_i ? rotated : tie_value_i;
                        slice_idx <= '0;
                    end
                    OP_LOAD: begin
                        out_o <= operand;
                    end
                    OP_CLEAR: begin
                        for (int i = 0; i < DIMENSION; i++) begin
                            counter[i] <= CNT_ZERO;
                        end
                        sample_cnt_o <= '0;
                    end
                    default: ;
                endcase
            end

            // One slice per cycle; bits outside the current slice keep their value.
            if (state == THRESH) begin
                for (int i = 0; i < DIMENSION; i++) begin
                    if (IDX_W'(i / SLICE_WIDTH) == slice_idx) begin
                        if (counter[i] > CNT_ZERO) begin
                            out_o[i] <= 1'b1;
                        end else if (counter[i] < CNT_ZERO) begin
                            out_o[i] <= 1'b0;
                        end else begin
                            out_o[i] <= tie_reg[i];
                        end
                    end
                end
                slice_idx <= slice_idx + IDX_W'(1);
            end
        end
    end

endmodule
